data_bus_responder: RTL and testbench

//  Memory-side responder for the core's load/store port: accepts one word request
//  (addr, we, wdata) over a valid/ready handshake and returns a one-cycle response

---
 rtl/data_bus_responder_if.sv | 22 ++
 rtl/data_bus_responder.sv | 149 ++++++++++++++
 tb/tb_data_bus_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_responder_if.sv
// Load/store port between the core's data side and the memory/IO responder.
// The master drives a word request; the slave answers with a one-cycle response strobe.
interface data_bus_responder_if;
    logic        req_valid_i;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/data_bus_responder.sv
// Memory-side responder: one word request at a time, fixed wait states, then a
// single-cycle response. Decodes data RAM, an LED register and a cycle counter.
module data_bus_responder #(
    parameter int          RAM_WORDS   = 256,
    parameter logic [31:0] RAM_BASE    = 32'h0000_2000,
    parameter logic [31:0] IO_BASE     = 32'h0000_7000,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] CNT_INIT    = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                reset_i,
    data_bus_responder_if.slave bus,
    output logic [15:0]         led_o
);
    localparam int         AW        = $clog2(RAM_WORDS);
    localparam logic [3:0] WCNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [31:0] CNT_ADDR = IO_BASE + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] led_q, led_d;
    logic [31:0] cnt_q, cnt_d;
    logic        enter_resp;

    logic [31:0] ram_mem [RAM_WORDS];
    logic        ram_we;

    logic [31:0]   cur_addr;
    logic          cur_we;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] ram_idx;
    logic          hit_ram, hit_led, hit_cnt, aligned, bad;

    // FSM: next state, request capture and the RESP-entry strobe
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d  = bus.req_addr_i;
                    we_d    = bus.req_we_i;
                    wdata_d = bus.req_wdata_i;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WCNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the RESP-entry edge is the accept edge itself, so the
    // decode must look at the live request rather than the latched copy.
    always_comb begin
        cur_addr  = (state_q == ST_IDLE) ? bus.req_addr_i  : addr_q;
        cur_we    = (state_q == ST_IDLE) ? bus.req_we_i    : we_q;
        cur_wdata = (state_q == ST_IDLE) ? bus.req_wdata_i : wdata_q;
        ram_idx   = cur_addr[AW+1:2];
        hit_ram   = (cur_addr[31:AW+2] == RAM_BASE[31:AW+2]);
        hit_led   = (cur_addr == IO_BASE);
        hit_cnt   = (cur_addr == CNT_ADDR);
        aligned   = (cur_addr[1:0] == 2'b00);
        bad       = !aligned || !(hit_ram || hit_led || hit_cnt) || (hit_cnt && cur_we);
    end

    always_comb begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        led_d   = led_q;
        ram_we  = 1'b0;
        cnt_d   = cnt_q + 32'd1;
        if (enter_resp) begin
            if (bad) begin
                err_d = 1'b1;
            end else if (cur_we) begin
                if (hit_ram) ram_we = 1'b1;
                else if (hit_led) led_d = cur_wdata[15:0];
            end else begin
                if (hit_ram)      rdata_d = ram_mem[ram_idx];
                else if (hit_led) rdata_d = {16'h0, led_q};
                else              rdata_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            led_q   <= 16'h0;
            cnt_q   <= CNT_INIT;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM is not cleared by reset; a reset edge just blocks the pending commit.
    always_ff @(posedge clk_i) begin
        if (!reset_i && ram_we) ram_mem[ram_idx] <= cur_wdata;
    end

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign led_o           = led_q;
endmodule

// File: tb/tb_data_bus_responder.sv
// Randomized bench for data_bus_responder: three instances (1 wait state, 1 wait state
// with counter preset near wrap, 0 wait states) checked against an address-map model.
module tb_data_bus_responder;
    localparam int          RAM_WORDS = 256;
    localparam logic [31:0] RAM_BASE  = 32'h0000_2000;
    localparam logic [31:0] IO_BASE   = 32'h0000_7000;
    localparam logic [31:0] INIT_W    = 32'hFFFF_FFF4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  sel;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] led, led0, led1, led2;

    data_bus_responder_if bus0 ();
    data_bus_responder_if bus1 ();
    data_bus_responder_if bus2 ();

    assign bus0.req_valid_i = req_valid && (sel == 2'd0);
    assign bus1.req_valid_i = req_valid && (sel == 2'd1);
    assign bus2.req_valid_i = req_valid && (sel == 2'd2);
    assign bus0.req_we_i = req_we;    assign bus1.req_we_i = req_we;    assign bus2.req_we_i = req_we;
    assign bus0.req_addr_i = req_addr; assign bus1.req_addr_i = req_addr; assign bus2.req_addr_i = req_addr;
    assign bus0.req_wdata_i = req_wdata; assign bus1.req_wdata_i = req_wdata; assign bus2.req_wdata_i = req_wdata;

    data_bus_responder #(.RAM_WORDS(RAM_WORDS), .RAM_BASE(RAM_BASE), .IO_BASE(IO_BASE),
        .WAIT_STATES(1), .CNT_INIT(32'h0)) dut0 (.clk_i(clk), .reset_i(reset), .bus(bus0), .led_o(led0));
    data_bus_responder #(.RAM_WORDS(RAM_WORDS), .RAM_BASE(RAM_BASE), .IO_BASE(IO_BASE),
        .WAIT_STATES(1), .CNT_INIT(INIT_W)) dut1 (.clk_i(clk), .reset_i(reset), .bus(bus1), .led_o(led1));
    data_bus_responder #(.RAM_WORDS(RAM_WORDS), .RAM_BASE(RAM_BASE), .IO_BASE(IO_BASE),
        .WAIT_STATES(0), .CNT_INIT(INIT_W)) dut2 (.clk_i(clk), .reset_i(reset), .bus(bus2), .led_o(led2));

    always_comb begin
        case (sel)
            2'd1:    begin ready = bus1.req_ready_o; rsp_valid = bus1.rsp_valid_o; rsp_rdata = bus1.rsp_rdata_o; rsp_err = bus1.rsp_err_o; led = led1; end
            2'd2:    begin ready = bus2.req_ready_o; rsp_valid = bus2.rsp_valid_o; rsp_rdata = bus2.rsp_rdata_o; rsp_err = bus2.rsp_err_o; led = led2; end
            default: begin ready = bus0.req_ready_o; rsp_valid = bus0.rsp_valid_o; rsp_rdata = bus0.rsp_rdata_o; rsp_err = bus0.rsp_err_o; led = led0; end
        endcase
    end

    // Non-reset edges since the last reset edge; the counter reads init plus this.
    logic [31:0] n_edges = 32'h0;
    always @(posedge clk) begin
        if (reset) n_edges <= 32'h0;
        else       n_edges <= n_edges + 32'd1;
    end

    int checks = 0;
    int failures = 0;

    logic [31:0] ram_m [3][RAM_WORDS];
    bit          ram_v [3][RAM_WORDS];
    logic [15:0] led_m [3];

    function automatic int ws_of(input logic [1:0] s);
        return (s == 2'd2) ? 0 : 1;
    endfunction

    function automatic logic [31:0] init_of(input logic [1:0] s);
        return (s == 2'd0) ? 32'h0 : INIT_W;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_check(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] got_rd,
                               input logic got_err, input logic [31:0] cnt_exp);
        bit in_ram, exp_err, rd_known;
        int idx;
        logic [31:0] exp_rd;
        in_ram   = (addr >= RAM_BASE) && (addr < RAM_BASE + 4 * RAM_WORDS);
        idx      = in_ram ? int'((addr - RAM_BASE) / 4) : 0;
        exp_err  = (addr % 4 != 0) || !(in_ram || addr == IO_BASE || (addr == IO_BASE + 4 && !we));
        exp_rd   = 32'h0;
        rd_known = 1'b1;
        if (!exp_err) begin
            if (we) begin
                if (in_ram) begin ram_m[sel][idx] = wdata; ram_v[sel][idx] = 1'b1; end
                else if (addr == IO_BASE) led_m[sel] = wdata[15:0];
            end else if (in_ram) begin
                rd_known = ram_v[sel][idx];
                exp_rd   = ram_m[sel][idx];
            end else if (addr == IO_BASE) exp_rd = {16'h0, led_m[sel]};
            else exp_rd = cnt_exp;
        end
        chk({tag, "_err"}, {31'h0, got_err}, {31'h0, exp_err});
        if (rd_known) chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_led"}, {16'h0, led}, {16'h0, led_m[sel]});
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold, input bit pulse_chk,
                       output logic [31:0] rd_seen);
        int k;
        logic [31:0] cexp;
        k = 0;
        while (!ready && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_ready"}, {31'h0, ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        if (hold) begin req_we = 1'b1; req_addr = IO_BASE; req_wdata = $urandom; end
        else req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        req_valid = 1'b0;
        chk({tag, "_lat"}, 32'(k), 32'(ws_of(sel)));
        cexp    = init_of(sel) + n_edges - 32'd1;
        rd_seen = rsp_rdata;
        model_check(tag, we, addr, wdata, rsp_rdata, rsp_err, cexp);
        if (pulse_chk) begin
            @(negedge clk);
            chk({tag, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
            chk({tag, "_idle"}, {31'h0, ready}, 32'h1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) led_m[s] = 16'h0;
    endtask

    task automatic cnt_sweep(input logic [1:0] s);
        logic [31:0] c, prev;
        bit wrapped;
        sel = s;
        do_reset();
        wrapped = 1'b0;
        prev = 32'h0;
        for (int i = 0; i < 12; i++) begin
            txn($sformatf("t6_s%0d_cnt", s), 1'b0, IO_BASE + 32'd4, 32'h0, 1'b0, 1'b0, c);
            if (i > 0) begin
                chk($sformatf("t6_s%0d_step", s), c - prev, 32'(ws_of(s) + 2));
                if (c < prev) wrapped = 1'b1;
            end
            prev = c;
        end
        chk($sformatf("t6_s%0d_wrap", s), {31'h0, wrapped}, 32'h1);
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] a;
        sel = 2'd0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int s = 0; s < 3; s++) begin
            led_m[s] = 16'h0;
            for (int w = 0; w < RAM_WORDS; w++) ram_v[s][w] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_ready", {31'h0, ready}, 32'h1);
        txn("t1_cnt", 1'b0, IO_BASE + 32'd4, 32'h0, 1'b0, 1'b1, c);
        chk("t1_cnt_ge3", {31'h0, c >= 32'd3}, 32'h1);

        txn("t2_st", 1'b1, 32'h2004, 32'hDEAD_BEEF, 1'b0, 1'b1, c);
        txn("t2_ld", 1'b0, 32'h2004, 32'h0, 1'b0, 1'b1, c);
        chk("t2_ld_val", c, 32'hDEAD_BEEF);

        txn("t3_st_led", 1'b1, IO_BASE, 32'h1234_A5A5, 1'b0, 1'b1, c);
        chk("t3_led", {16'h0, led}, 32'h0000_A5A5);
        txn("t3_ld_led", 1'b0, IO_BASE, 32'h0, 1'b0, 1'b1, c);
        txn("t3_st_cnt", 1'b1, IO_BASE + 32'd4, 32'h0, 1'b0, 1'b1, c);
        txn("t3_ld_cnt", 1'b0, IO_BASE + 32'd4, 32'h0, 1'b0, 1'b1, c);

        txn("t4_mis", 1'b0, 32'h2002, 32'h0, 1'b0, 1'b1, c);
        txn("t4_unm", 1'b0, 32'h0000_9000, 32'h0, 1'b0, 1'b1, c);
        txn("t4_st0", 1'b1, 32'h2000, 32'h0BAD_F00D, 1'b0, 1'b1, c);
        txn("t4_st_mis", 1'b1, 32'h2002, 32'hFFFF_FFFF, 1'b0, 1'b1, c);
        txn("t4_ld0", 1'b0, 32'h2000, 32'h0, 1'b0, 1'b1, c);

        // Reset while a store sits in WAIT: no response, store dropped.
        txn("t5_st_a", 1'b1, 32'h2008, 32'h5555_AAAA, 1'b0, 1'b1, c);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2008; req_wdata = 32'h1111_2222;
        @(negedge clk);
        chk("t5_in_wait", {31'h0, ready}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_no_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("t5_idle", {31'h0, ready}, 32'h1);
        chk("t5_led_clr", {16'h0, led}, 32'h0);
        reset = 1'b0; req_valid = 1'b0;
        for (int s = 0; s < 3; s++) led_m[s] = 16'h0;
        txn("t5_ld", 1'b0, 32'h2008, 32'h0, 1'b0, 1'b1, c);
        chk("t5_ld_val", c, 32'h5555_AAAA);
        txn("t5_hold", 1'b1, 32'h200C, 32'hCAFE_0001, 1'b1, 1'b1, c);
        txn("t5_ld_led", 1'b0, IO_BASE, 32'h0, 1'b0, 1'b1, c);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = RAM_BASE + 4 * $urandom_range(0, 15);
                2:       a = RAM_BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
                3:       a = IO_BASE;
                4:       a = IO_BASE + 32'd4;
                5:       a = ($urandom_range(0, 1) != 0) ? RAM_BASE + 4 * RAM_WORDS : RAM_BASE - 32'd4;
                6:       a = ($urandom_range(0, 1) != 0) ? RAM_BASE + 4 * (RAM_WORDS - 1) : $urandom;
                default: a = ($urandom_range(0, 1) != 0) ? IO_BASE + 32'd8 : IO_BASE - 32'd4;
            endcase
            txn("rnd", 1'($urandom_range(0, 1)), a, $urandom, 1'b0, 1'($urandom_range(0, 1)), c);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        cnt_sweep(2'd1);
        cnt_sweep(2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
